// File: rtl/sdcard_writeback.sv
// sdcard_writeback: streams RAM words 0..MAX_RAM_ADDRESS-1 onto a raw SD card,
// high byte first, one 512-byte block (256 words) per controller write.
// A partial last block is padded with 16'h0000 words.
// Optional feature: define WB_CHECKSUM_EN to build a 16-bit wrapping sum of
// every real RAM word sent; without it wb_checksum is tied to zero.
//
// Ports:
//   clk50, reset          clock, synchronous active-high reset
//   start                 one-cycle pulse, begins a dump from IDLE
//   ram_re/ram_address    RAM read request and word address
//   ram_data/_valid       RAM read data and acknowledge
//   sd_wr/sd_continue     block write request / multi-block continuation
//   sd_block_addr         byte address (SD) or block number (SDHC)
//   sd_data/sd_hndshk_o   byte and strobe to controller
//   sd_hndshk_i           byte taken by controller
//   sd_busy/sd_error      controller status
//   wb_busy/done/error    dump status (done/error sticky until reset)
//   wb_checksum           sum of real words sent
module sdcard_writeback #(
  parameter logic [24:0] MAX_RAM_ADDRESS = 25'h3FFFFF,
  parameter logic        SDHC            = 1'b0
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        start,
  output logic        ram_re,
  output logic [24:0] ram_address,
  input  logic [15:0] ram_data,
  input  logic        ram_data_valid,
  output logic        sd_wr,
  output logic        sd_continue,
  output logic [31:0] sd_block_addr,
  output logic [7:0]  sd_data,
  output logic        sd_hndshk_o,
  input  logic        sd_hndshk_i,
  input  logic        sd_busy,
  input  logic [15:0] sd_error,
  output logic        wb_busy,
  output logic        wb_done,
  output logic        wb_error,
  output logic [15:0] wb_checksum
);

  localparam int unsigned AW = 25;
  // One extra bit so padding past the top of RAM never wraps back to zero.
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] MAX_EXT = CW'(MAX_RAM_ADDRESS);

  typedef enum logic [3:0] {
    IDLE, WAIT_CTRL, START_BLK, FETCH, SENDH_0, SENDH_1,
    SENDL_0, SENDL_1, NEXT, BLK_END, DONE, ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] addr_q, addr_d;
  logic [15:0]   word_q, word_d;
  logic          first_q, first_d;
  logic          past_end;
  logic          capture;

  logic          ram_re_d, sd_wr_d, sd_continue_d, sd_hndshk_o_d;
  logic          wb_busy_d, wb_done_d, wb_error_d;
  logic [7:0]    sd_data_d;

  assign past_end = (addr_q >= MAX_EXT);
  assign capture  = (state_q == FETCH) && sd_busy && !past_end && ram_data_valid;

  assign ram_address   = addr_q[AW-1:0];
  assign sd_block_addr = SDHC ? 32'(addr_q[AW-1:8]) : {6'b0, addr_q[AW-1:0], 1'b0};

  // State, datapath and registered outputs.
  always_ff @(posedge clk50) begin : state_reg
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      word_q      <= '0;
      first_q     <= 1'b0;
      ram_re      <= 1'b0;
      sd_wr       <= 1'b0;
      sd_continue <= 1'b0;
      sd_hndshk_o <= 1'b0;
      sd_data     <= '0;
      wb_busy     <= 1'b0;
      wb_done     <= 1'b0;
      wb_error    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      first_q     <= first_d;
      ram_re      <= ram_re_d;
      sd_wr       <= sd_wr_d;
      sd_continue <= sd_continue_d;
      sd_hndshk_o <= sd_hndshk_o_d;
      sd_data     <= sd_data_d;
      wb_busy     <= wb_busy_d;
      wb_done     <= wb_done_d;
      wb_error    <= wb_error_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin : next_state
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    first_d = first_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = '0;
          first_d = 1'b1;
          state_d = WAIT_CTRL;
        end
      end
      // Both wait for the controller to go idle, then apply the same end/error rules.
      WAIT_CTRL, BLK_END: begin
        if (!sd_busy) begin
          if (sd_error != 16'h0000) state_d = ERROR;
          else if (past_end)        state_d = DONE;
          else                      state_d = START_BLK;
        end
      end
      START_BLK: begin
        if (sd_busy) begin
          first_d = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (!sd_busy) state_d = ERROR;
        else if (past_end) begin
          word_d  = 16'h0000;
          state_d = SENDH_0;
        end else if (capture) begin
          word_d  = ram_data;
          state_d = SENDH_0;
        end
      end
      SENDH_0: begin
        if (!sd_busy)        state_d = ERROR;
        else if (sd_hndshk_i) state_d = SENDH_1;
      end
      SENDH_1: begin
        if (!sd_busy)         state_d = ERROR;
        else if (!sd_hndshk_i) state_d = SENDL_0;
      end
      SENDL_0: begin
        if (!sd_busy)        state_d = ERROR;
        else if (sd_hndshk_i) state_d = SENDL_1;
      end
      SENDL_1: begin
        if (!sd_busy)         state_d = ERROR;
        else if (!sd_hndshk_i) state_d = NEXT;
      end
      NEXT: begin
        if (!sd_busy) state_d = ERROR;
        else begin
          addr_d  = addr_q + CW'(1);
          state_d = (addr_q[7:0] == 8'hFF) ? BLK_END : FETCH;
        end
      end
      DONE, ERROR: state_d = state_q;
      default:     state_d = IDLE;
    endcase
  end

  // Output values for the state being entered, registered in state_reg.
  always_comb begin : output_dec
    ram_re_d      = 1'b0;
    sd_wr_d       = 1'b0;
    sd_continue_d = 1'b0;
    sd_hndshk_o_d = 1'b0;
    sd_data_d     = sd_data;
    wb_busy_d     = 1'b1;
    wb_done_d     = 1'b0;
    wb_error_d    = 1'b0;
    case (state_d)
      IDLE:  wb_busy_d = 1'b0;
      DONE: begin
        wb_busy_d = 1'b0;
        wb_done_d = 1'b1;
      end
      ERROR: begin
        wb_busy_d  = 1'b0;
        wb_error_d = 1'b1;
      end
      START_BLK: begin
        sd_wr_d       = 1'b1;
        sd_continue_d = !first_d;
      end
      // Padding words never touch the RAM.
      FETCH: ram_re_d = (addr_d < MAX_EXT);
      SENDH_0: begin
        sd_hndshk_o_d = 1'b1;
        sd_data_d     = word_d[15:8];
      end
      SENDL_0: begin
        sd_hndshk_o_d = 1'b1;
        sd_data_d     = word_d[7:0];
      end
      default: ;
    endcase
  end

`ifdef WB_CHECKSUM_EN
  logic [15:0] csum_q;

  // Wrapping sum of real RAM words, cleared when a dump starts.
  always_ff @(posedge clk50) begin : checksum_reg
    if (reset)                         csum_q <= '0;
    else if (state_q == IDLE && start) csum_q <= '0;
    else if (capture)                  csum_q <= csum_q + ram_data;
  end

  assign wb_checksum = csum_q;
`else
  assign wb_checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_sdcard_writeback.sv
// Bench for sdcard_writeback: three instances (SD MAX=0x101, SDHC MAX=0x300,
// MAX=0) driven by a RAM responder and an SD controller responder, each with
// randomized latencies; recorded traffic is compared with a reference
// computed directly from the RAM image.
module tb_sdcard_writeback;

  localparam int NI = 3;

  logic clk50 = 1'b0;
  logic reset;

  logic [NI-1:0]        start;
  logic [NI-1:0]        ram_re;
  logic [NI-1:0][24:0]  ram_address;
  logic [NI-1:0][15:0]  ram_data;
  logic [NI-1:0]        ram_data_valid;
  logic [NI-1:0]        sd_wr;
  logic [NI-1:0]        sd_continue;
  logic [NI-1:0][31:0]  sd_block_addr;
  logic [NI-1:0][7:0]   sd_data;
  logic [NI-1:0]        sd_hndshk_o;
  logic [NI-1:0]        sd_hndshk_i;
  logic [NI-1:0]        sd_busy;
  logic [NI-1:0][15:0]  sd_error;
  logic [NI-1:0]        wb_busy;
  logic [NI-1:0]        wb_done;
  logic [NI-1:0]        wb_error;
  logic [NI-1:0][15:0]  wb_checksum;

  logic [15:0] ram [0:1023];
  int          lat_fixed;

  // Traffic recorded by the responders.
  logic [7:0]  got_bytes [NI][2048];
  logic [31:0] blk_addr  [NI][8];
  logic        blk_cont  [NI][8];
  int nbytes [NI];
  int nblk   [NI];
  int wr_cycles [NI];
  int nreads [NI];
  int re_min [NI];
  int re_max [NI];
  int addr_bad [NI];
  int data_bad [NI];

  int checks = 0;
  int failures = 0;

  initial forever #5 clk50 = ~clk50;

  for (genvar k = 0; k < NI; k++) begin : g_inst
    sdcard_writeback #(
      .MAX_RAM_ADDRESS((k == 0) ? 25'h101 : ((k == 1) ? 25'h300 : 25'h000)),
      .SDHC(1'(k == 1))
    ) u_dut (
      .clk50(clk50),
      .reset(reset),
      .start(start[k]),
      .ram_re(ram_re[k]),
      .ram_address(ram_address[k]),
      .ram_data(ram_data[k]),
      .ram_data_valid(ram_data_valid[k]),
      .sd_wr(sd_wr[k]),
      .sd_continue(sd_continue[k]),
      .sd_block_addr(sd_block_addr[k]),
      .sd_data(sd_data[k]),
      .sd_hndshk_o(sd_hndshk_o[k]),
      .sd_hndshk_i(sd_hndshk_i[k]),
      .sd_busy(sd_busy[k]),
      .sd_error(sd_error[k]),
      .wb_busy(wb_busy[k]),
      .wb_done(wb_done[k]),
      .wb_error(wb_error[k]),
      .wb_checksum(wb_checksum[k])
    );

    // RAM and SD controller responder, acting on the falling edge.
    initial begin : responder
      int re_len, lat, left, hs_wait, busy_wait, tail;
      logic blk_active, prev_o;
      logic [24:0] re_addr;
      logic [7:0] held;
      re_len = 0; lat = 0; left = 0; hs_wait = 0; busy_wait = 0; tail = 0;
      blk_active = 1'b0; prev_o = 1'b0; re_addr = '0; held = '0;
      ram_data_valid[k] = 1'b0; ram_data[k] = '0;
      sd_busy[k] = 1'b0; sd_hndshk_i[k] = 1'b0;
      forever begin
        @(negedge clk50);
        if (reset) begin
          nbytes[k] = 0; nblk[k] = 0; wr_cycles[k] = 0; nreads[k] = 0;
          re_min[k] = 1000; re_max[k] = 0; addr_bad[k] = 0; data_bad[k] = 0;
          re_len = 0; blk_active = 1'b0; prev_o = 1'b0;
          ram_data_valid[k] = 1'b0; sd_busy[k] = 1'b0; sd_hndshk_i[k] = 1'b0;
        end else begin
          // RAM side
          if (ram_re[k]) begin
            if (re_len == 0) re_addr = ram_address[k];
            else if (ram_address[k] != re_addr) addr_bad[k]++;
            re_len++;
            if (re_len == lat + 1) begin
              ram_data_valid[k] = 1'b1;
              ram_data[k] = ram[ram_address[k][9:0]];
              nreads[k]++;
            end else ram_data_valid[k] = 1'b0;
          end else begin
            if (re_len > 0) begin
              if (re_len < re_min[k]) re_min[k] = re_len;
              if (re_len > re_max[k]) re_max[k] = re_len;
            end
            ram_data_valid[k] = 1'b0;
            re_len = 0;
            lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 2));
          end
          // byte must not change while the strobe waits for acceptance
          if (sd_hndshk_o[k] && !prev_o) held = sd_data[k];
          else if (sd_hndshk_o[k] && !sd_hndshk_i[k] && sd_data[k] != held) data_bad[k]++;
          prev_o = sd_hndshk_o[k];
          if (sd_wr[k]) wr_cycles[k]++;
          // SD controller side
          if (!blk_active) begin
            sd_busy[k] = 1'b0;
            sd_hndshk_i[k] = 1'b0;
            if (sd_wr[k]) begin
              if (nblk[k] < 8) begin
                blk_addr[k][nblk[k]] = sd_block_addr[k];
                blk_cont[k][nblk[k]] = sd_continue[k];
              end
              nblk[k]++;
              blk_active = 1'b1;
              left = 512;
              busy_wait = int'($urandom_range(0, 2));
              hs_wait = int'($urandom_range(0, 1));
            end
          end else if (!sd_busy[k]) begin
            if (busy_wait == 0) sd_busy[k] = 1'b1;
            else busy_wait--;
          end else if (left > 0) begin
            if (!sd_hndshk_i[k]) begin
              if (sd_hndshk_o[k]) begin
                if (hs_wait == 0) begin
                  if (nbytes[k] < 2048) got_bytes[k][nbytes[k]] = sd_data[k];
                  nbytes[k]++;
                  sd_hndshk_i[k] = 1'b1;
                  hs_wait = int'($urandom_range(0, 1));
                end else hs_wait--;
              end
            end else if (!sd_hndshk_o[k]) begin
              sd_hndshk_i[k] = 1'b0;
              left--;
              if (left == 0) tail = 3 + int'($urandom_range(0, 2));
            end
          end else begin
            if (tail == 0) begin
              sd_busy[k] = 1'b0;
              blk_active = 1'b0;
            end else tail--;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    tick(1);
    start[k] = 1'b0;
  endtask

  task automatic wait_end(input int k, input int budget, input string tag);
    int n;
    n = 0;
    while (!(wb_done[k] || wb_error[k]) && n < budget) begin
      tick(1);
      n++;
    end
    chk({tag, "_finished"}, 32'(n < budget), 32'd1);
  endtask

  // Expected traffic derived from the RAM image and the dump range.
  task automatic check_dump(input int k, input int maxa, input bit sdhc, input string tag);
    int nblocks, bad;
    logic [15:0] w, sum;
    nblocks = (maxa + 255) / 256;
    bad = 0;
    sum = 16'h0000;
    for (int a = 0; a < nblocks * 256; a++) begin
      w = (a < maxa) ? ram[a] : 16'h0000;
      if (a < maxa) sum = sum + ram[a];
      if (got_bytes[k][2*a] !== w[15:8] || got_bytes[k][2*a+1] !== w[7:0]) bad++;
    end
    chk({tag, "_done"}, 32'(wb_done[k]), 32'd1);
    chk({tag, "_error"}, 32'(wb_error[k]), 32'd0);
    chk({tag, "_busy"}, 32'(wb_busy[k]), 32'd0);
    chk({tag, "_nbytes"}, 32'(nbytes[k]), 32'(nblocks * 512));
    chk({tag, "_nblocks"}, 32'(nblk[k]), 32'(nblocks));
    for (int b = 0; b < nblocks && b < 8; b++) begin
      chk({tag, "_blkaddr"}, blk_addr[k][b], sdhc ? 32'(b) : 32'(b * 512));
      chk({tag, "_continue"}, 32'(blk_cont[k][b]), 32'(b != 0));
    end
    chk({tag, "_reads"}, 32'(nreads[k]), 32'(maxa));
    chk({tag, "_bad_bytes"}, 32'(bad), 32'd0);
    chk({tag, "_data_unstable"}, 32'(data_bad[k]), 32'd0);
    if (nblocks == 0) chk({tag, "_wr_cycles"}, 32'(wr_cycles[k]), 32'd0);
`ifdef WB_CHECKSUM_EN
    chk({tag, "_checksum"}, 32'(wb_checksum[k]), 32'(sum));
`else
    chk({tag, "_checksum"}, 32'(wb_checksum[k]), 32'd0);
`endif
  endtask

  initial begin : stimulus
    int n;
    reset = 1'b1;
    start = '0;
    sd_error = '0;
    lat_fixed = -1;
    for (int i = 0; i < 1024; i++) ram[i] = 16'(i);
    tick(3);

    // Reset state
    chk("rst_ram_re", 32'(ram_re[0]), 32'd0);
    chk("rst_ram_address", 32'(ram_address[0]), 32'd0);
    chk("rst_sd_wr", 32'(sd_wr[0]), 32'd0);
    chk("rst_sd_hndshk_o", 32'(sd_hndshk_o[0]), 32'd0);
    chk("rst_sd_data", 32'(sd_data[0]), 32'd0);
    chk("rst_wb_busy", 32'(wb_busy[0]), 32'd0);
    chk("rst_wb_done", 32'(wb_done[0]), 32'd0);
    chk("rst_wb_error", 32'(wb_error[0]), 32'd0);
    chk("rst_checksum", 32'(wb_checksum[0]), 32'd0);

    // Ramp image on all three instances at once
    reset = 1'b0;
    tick(2);
    start = '1;
    tick(1);
    start = '0;
    tick(2);
    chk("run1_busy_mid", 32'(wb_busy[0]), 32'd1);
    chk("max0_done", 32'(wb_done[2]), 32'd1);
    wait_end(0, 20000, "run1_sd");
    wait_end(1, 20000, "run1_sdhc");
    wait_end(2, 100, "run1_max0");
    check_dump(0, 'h101, 1'b0, "run1_sd");
    check_dump(1, 'h300, 1'b1, "run1_sdhc");
    check_dump(2, 0, 1'b0, "run1_max0");

    // Random image, reset in the middle of word 5's low byte
    reset = 1'b1;
    for (int i = 0; i < 1024; i++) ram[i] = 16'($urandom);
    tick(2);
    reset = 1'b0;
    tick(1);
    pulse_start(0);
    n = 0;
    while (!(nbytes[0] == 11 && sd_hndshk_o[0]) && n < 3000) begin
      tick(1);
      n++;
    end
    chk("reach_word5_low", 32'(n < 3000), 32'd1);
    chk("word5_address", 32'(ram_address[0]), 32'd5);
    chk("word5_low_byte", 32'(sd_data[0]), 32'(ram[5][7:0]));
    reset = 1'b1;
    tick(1);
    chk("midrst_ram_re", 32'(ram_re[0]), 32'd0);
    chk("midrst_ram_address", 32'(ram_address[0]), 32'd0);
    chk("midrst_sd_wr", 32'(sd_wr[0]), 32'd0);
    chk("midrst_sd_continue", 32'(sd_continue[0]), 32'd0);
    chk("midrst_sd_hndshk_o", 32'(sd_hndshk_o[0]), 32'd0);
    chk("midrst_sd_data", 32'(sd_data[0]), 32'd0);
    chk("midrst_wb_busy", 32'(wb_busy[0]), 32'd0);
    tick(1);
    reset = 1'b0;

    // Restart from address 0 with a 7-cycle RAM acknowledge delay
    lat_fixed = 7;
    tick(1);
    pulse_start(0);
    wait_end(0, 20000, "restart");
    check_dump(0, 'h101, 1'b0, "restart");
    chk("slow_re_min", 32'(re_min[0]), 32'd8);
    chk("slow_re_max", 32'(re_max[0]), 32'd8);
    chk("slow_addr_stable", 32'(addr_bad[0]), 32'd0);
    lat_fixed = -1;

    // Controller error before the first block
    reset = 1'b1;
    sd_error[0] = 16'h0011;
    tick(2);
    reset = 1'b0;
    tick(1);
    pulse_start(0);
    wait_end(0, 50, "err");
    chk("err_wb_error", 32'(wb_error[0]), 32'd1);
    chk("err_wb_done", 32'(wb_done[0]), 32'd0);
    chk("err_wb_busy", 32'(wb_busy[0]), 32'd0);
    chk("err_wr_cycles", 32'(wr_cycles[0]), 32'd0);
    sd_error[0] = 16'h0000;
    tick(2);
    pulse_start(0);
    tick(10);
    chk("err_sticky", 32'(wb_error[0]), 32'd1);
    chk("err_start_ignored", 32'(wb_busy[0]), 32'd0);
    chk("err_no_wr_after", 32'(wr_cycles[0]), 32'd0);
    chk("err_still_not_done", 32'(wb_done[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
